// File: rtl/cla_checker_if.sv
// Bus bundle for the cla_checker response monitor.
// master: stimulus/adder side (drives operands, adder result and run control)
// slave : the checker (returns status, counters and first-failure capture)
interface cla_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    // run control
    logic             start;
    logic             stop;
    // operands as driven to the adder, and the adder's response
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    // status and verdict
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    // first-failure capture
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic             cap_cin;
    logic [WIDTH-1:0] cap_s;
    logic             cap_cout;
    logic             cap_vld;

    modport master (
        output start, stop, A, B, Cin, S, Cout,
        input  busy, done, pass, vec_cnt, err_cnt,
        input  cap_a, cap_b, cap_cin, cap_s, cap_cout, cap_vld
    );

    modport slave (
        input  start, stop, A, B, Cin, S, Cout,
        output busy, done, pass, vec_cnt, err_cnt,
        output cap_a, cap_b, cap_cin, cap_s, cap_cout, cap_vld
    );
endinterface

// File: rtl/cla_checker.sv
// cla_checker: self-checking response monitor for a clocked carry-look-ahead
// adder. Operands are delayed by LAT cycles so they line up with the adder's
// S/Cout, compared against a golden WIDTH+1 bit sum, and counted.
//
// Optional feature macro: CLA_CHECK_CAPTURE_EN
//   defined   -> first failing vector of a run is latched into cap_*.
//   undefined -> no capture registers; cap_* and cap_vld are tied to 0.
//
// LAT must lie in 0..4; LAT=0 compares against the live operands.
module cla_checker #(
    parameter int WIDTH = 4,
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    cla_checker_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int              DLY_W     = 2 * WIDTH + 1;
    localparam logic [2:0]      FILL_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // ------------------------------------------------------------------
    // Operand delay line
    // ------------------------------------------------------------------
    logic [DLY_W-1:0] w_live;
    logic [DLY_W-1:0] w_dly_out;
    logic [WIDTH-1:0] w_a_d;
    logic [WIDTH-1:0] w_b_d;
    logic             w_cin_d;

    assign w_live = {bus.A, bus.B, bus.Cin};

    generate
        if (LAT == 0) begin : g_no_dly
            assign w_dly_out = w_live;
        end else begin : g_dly
            logic [DLY_W-1:0] r_dly [LAT];

            // Shift the operand bundle one stage per cycle, regardless of state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) begin
                        r_dly[i] <= '0;
                    end
                end else begin
                    r_dly[0] <= w_live;
                    for (int i = 1; i < LAT; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign w_dly_out = r_dly[LAT-1];
        end
    endgenerate

    assign w_a_d   = w_dly_out[DLY_W-1 -: WIDTH];
    assign w_b_d   = w_dly_out[WIDTH:1];
    assign w_cin_d = w_dly_out[0];

    // ------------------------------------------------------------------
    // Golden sum and compare
    // ------------------------------------------------------------------
    logic [WIDTH:0] w_exp;
    logic           w_mis;

    assign w_exp = {1'b0, w_a_d} + {1'b0, w_b_d} + (WIDTH + 1)'(w_cin_d);
    assign w_mis = ({bus.Cout, bus.S} != w_exp);

    // ------------------------------------------------------------------
    // Control FSM and counters
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_fill;
    logic [2:0]       w_fill_nxt;
    logic [CNT_W-1:0] r_vec;
    logic [CNT_W-1:0] w_vec_nxt;
    logic [CNT_W-1:0] r_err;
    logic [CNT_W-1:0] w_err_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             w_start_acc;
    logic             w_cmp;

    // start is only honoured from IDLE/DONE; compares happen only in CHECK.
    assign w_start_acc = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cmp       = (r_state == ST_CHECK);

    // Next-state, fill counter and run counters.
    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_vec_nxt   = r_vec;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_acc) begin
                    w_vec_nxt   = '0;
                    w_err_nxt   = '0;
                    w_fill_nxt  = 3'd0;
                    w_state_nxt = (LAT == 0) ? ST_CHECK : ST_FILL;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_FILL: begin
                if (bus.stop) begin
                    w_state_nxt = ST_DONE;
                end else if (r_fill == FILL_LAST) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_fill_nxt  = r_fill + 3'd1;
                end
            end
            ST_CHECK: begin
                w_vec_nxt = sat_inc(r_vec);
                if (w_mis) begin
                    w_err_nxt = sat_inc(r_err);
                end else begin
                    w_err_nxt = r_err;
                end
                // the stop cycle is still compared above
                if (bus.stop) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_CHECK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_fill  <= 3'd0;
            r_vec   <= '0;
            r_err   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_vec   <= w_vec_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt == ST_FILL) || (w_state_nxt == ST_CHECK);
            r_done  <= (w_state_nxt == ST_DONE);
            r_pass  <= (w_state_nxt == ST_DONE) && (w_err_nxt == '0) && (w_vec_nxt != '0);
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.vec_cnt = r_vec;
    assign bus.err_cnt = r_err;

    // ------------------------------------------------------------------
    // First-failure capture
    // ------------------------------------------------------------------
`ifdef CLA_CHECK_CAPTURE_EN
    logic [WIDTH-1:0] r_cap_a;
    logic [WIDTH-1:0] r_cap_b;
    logic             r_cap_cin;
    logic [WIDTH-1:0] r_cap_s;
    logic             r_cap_cout;
    logic             r_cap_vld;
    logic             w_cap_ld;

    // Load only on the first mismatch of a run.
    always_comb begin
        w_cap_ld = 1'b0;
        if (w_cmp && w_mis && !r_cap_vld) begin
            w_cap_ld = 1'b1;
        end else begin
            w_cap_ld = 1'b0;
        end
    end

    // Capture registers: cleared on an accepted start, loaded once per run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_a    <= '0;
            r_cap_b    <= '0;
            r_cap_cin  <= 1'b0;
            r_cap_s    <= '0;
            r_cap_cout <= 1'b0;
            r_cap_vld  <= 1'b0;
        end else if (w_start_acc) begin
            r_cap_a    <= '0;
            r_cap_b    <= '0;
            r_cap_cin  <= 1'b0;
            r_cap_s    <= '0;
            r_cap_cout <= 1'b0;
            r_cap_vld  <= 1'b0;
        end else if (w_cap_ld) begin
            r_cap_a    <= w_a_d;
            r_cap_b    <= w_b_d;
            r_cap_cin  <= w_cin_d;
            r_cap_s    <= bus.S;
            r_cap_cout <= bus.Cout;
            r_cap_vld  <= 1'b1;
        end
    end

    assign bus.cap_a    = r_cap_a;
    assign bus.cap_b    = r_cap_b;
    assign bus.cap_cin  = r_cap_cin;
    assign bus.cap_s    = r_cap_s;
    assign bus.cap_cout = r_cap_cout;
    assign bus.cap_vld  = r_cap_vld;
`else
    assign bus.cap_a    = '0;
    assign bus.cap_b    = '0;
    assign bus.cap_cin  = 1'b0;
    assign bus.cap_s    = '0;
    assign bus.cap_cout = 1'b0;
    assign bus.cap_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_cla_checker.sv
// Testbench for cla_checker. Acts as the adder (with fault injection) for two
// checker instances: u0 (LAT=1, CNT_W=16) and u1 (LAT=3, CNT_W=3).
module tb_cla_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef CLA_CHECK_CAPTURE_EN
    localparam bit CAP_EN = 1'b1;
`else
    localparam bit CAP_EN = 1'b0;
`endif

    logic       tb_start0 = 1'b0, tb_stop0 = 1'b0;
    logic       tb_start1 = 1'b0, tb_stop1 = 1'b0;
    logic [3:0] tb_a = 4'd0, tb_b = 4'd0, tb_s = 4'd0;
    logic       tb_cin = 1'b0, tb_cout = 1'b0;

    cla_checker_if #(.WIDTH(4), .CNT_W(16)) if0 ();
    cla_checker_if #(.WIDTH(4), .CNT_W(3))  if1 ();

    assign if0.start = tb_start0;
    assign if0.stop  = tb_stop0;
    assign if0.A     = tb_a;
    assign if0.B     = tb_b;
    assign if0.Cin   = tb_cin;
    assign if0.S     = tb_s;
    assign if0.Cout  = tb_cout;
    assign if1.start = tb_start1;
    assign if1.stop  = tb_stop1;
    assign if1.A     = tb_a;
    assign if1.B     = tb_b;
    assign if1.Cin   = tb_cin;
    assign if1.S     = tb_s;
    assign if1.Cout  = tb_cout;

    cla_checker #(.WIDTH(4), .LAT(1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    cla_checker #(.WIDTH(4), .LAT(3), .CNT_W(3))  u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_vec = 0;
    int n_bad = 0;

    // adder model: history of presented operands plus the error mask to apply
    logic [3:0] h_a [8];
    logic [3:0] h_b [8];
    logic       h_c [8];
    logic [4:0] h_m [8];
    int         cur_lat = 1;

    // snapshot of one instance's outputs
    int o_busy, o_done, o_pass, o_vec, o_err, o_cvld, o_ca, o_cb, o_ccin, o_cs, o_ccout;

    typedef struct {
        int inst; int n; int pat; int fidx; int fmode;
        int exp_vec; int exp_err; int exp_pass;
        int exp_cvld; int exp_ca; int exp_cb; int exp_ccin; int exp_cs; int exp_ccout;
    } run_t;

    run_t runs [3];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic snap(input int inst);
        if (inst == 0) begin
            o_busy = int'(if0.busy); o_done = int'(if0.done); o_pass = int'(if0.pass);
            o_vec = int'(if0.vec_cnt); o_err = int'(if0.err_cnt); o_cvld = int'(if0.cap_vld);
            o_ca = int'(if0.cap_a); o_cb = int'(if0.cap_b); o_ccin = int'(if0.cap_cin);
            o_cs = int'(if0.cap_s); o_ccout = int'(if0.cap_cout);
        end else begin
            o_busy = int'(if1.busy); o_done = int'(if1.done); o_pass = int'(if1.pass);
            o_vec = int'(if1.vec_cnt); o_err = int'(if1.err_cnt); o_cvld = int'(if1.cap_vld);
            o_ca = int'(if1.cap_a); o_cb = int'(if1.cap_b); o_ccin = int'(if1.cap_cin);
            o_cs = int'(if1.cap_s); o_ccout = int'(if1.cap_cout);
        end
    endtask

    // One clock cycle: present operands/control, show the adder result of the
    // operands presented cur_lat cycles earlier (XOR'd with its error mask).
    task automatic step(input logic st0, input logic sp0, input logic st1, input logic sp1,
                        input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [4:0] m);
        logic [4:0] shown;
        @(negedge clk);
        for (int k = 7; k > 0; k--) begin
            h_a[k] = h_a[k-1]; h_b[k] = h_b[k-1]; h_c[k] = h_c[k-1]; h_m[k] = h_m[k-1];
        end
        h_a[0] = a; h_b[0] = b; h_c[0] = c; h_m[0] = m;
        tb_a = a; tb_b = b; tb_cin = c;
        tb_start0 = st0; tb_stop0 = sp0; tb_start1 = st1; tb_stop1 = sp1;
        shown = (5'(h_a[cur_lat]) + 5'(h_b[cur_lat]) + 5'(h_c[cur_lat])) ^ h_m[cur_lat];
        {tb_cout, tb_s} = shown;
        @(posedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        tb_start0 = 1'b0; tb_stop0 = 1'b0; tb_start1 = 1'b0; tb_stop1 = 1'b0;
    endtask

    task automatic chk_end(input string tag, input int inst, input int ev, input int ee,
                           input int ep, input int cv, input int ca, input int cb,
                           input int cc, input int cs, input int cco);
        snap(inst);
        chk({tag, " busy"}, o_busy, 0);
        chk({tag, " done"}, o_done, 1);
        chk({tag, " pass"}, o_pass, ep);
        chk({tag, " vec_cnt"}, o_vec, ev);
        chk({tag, " err_cnt"}, o_err, ee);
        chk({tag, " cap_vld"}, o_cvld, CAP_EN ? cv : 0);
        chk({tag, " cap_a"}, o_ca, CAP_EN ? ca : 0);
        chk({tag, " cap_b"}, o_cb, CAP_EN ? cb : 0);
        chk({tag, " cap_cin"}, o_ccin, CAP_EN ? cc : 0);
        chk({tag, " cap_s"}, o_cs, CAP_EN ? cs : 0);
        chk({tag, " cap_cout"}, o_ccout, CAP_EN ? cco : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int k = 0; k < 8; k++) begin
            h_a[k] = 4'd0; h_b[k] = 4'd0; h_c[k] = 1'b0; h_m[k] = 5'd0;
        end

        // scenario table: correct run, single injected fault, saturation
        runs[0] = '{0, 16, 0, -2, 0, 16, 0, 1, 0, 0, 0, 0, 0, 0};
        runs[1] = '{0, 16, 1,  4, 1, 16, 1, 0, 1, 4, 0, 0, 0, 0};
        runs[2] = '{1, 12, 0, -1, 2,  7, 7, 0, 1, 0, 15, 0, 0, 0};

        // reset values (reset still asserted)
        repeat (3) @(negedge clk);
        snap(0);
        chk("rst busy", o_busy, 0);
        chk("rst done", o_done, 0);
        chk("rst pass", o_pass, 0);
        chk("rst vec_cnt", o_vec, 0);
        chk("rst err_cnt", o_err, 0);
        chk("rst cap_vld", o_cvld, 0);
        snap(1);
        chk("rst u1 vec_cnt", o_vec, 0);
        chk("rst u1 busy", o_busy, 0);
        rst = 1'b0;

        // stop while idle is ignored
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
        settle();
        snap(0);
        chk("idle stop done", o_done, 0);
        chk("idle stop busy", o_busy, 0);

        // table-driven runs
        for (int r = 0; r < 3; r++) begin
            logic [3:0] a, b;
            logic       c;
            logic [4:0] sum, m;
            cur_lat = (runs[r].inst == 0) ? 1 : 3;
            step(runs[r].inst == 0, 1'b0, runs[r].inst == 1, 1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
            for (int i = 0; i < runs[r].n; i++) begin
                a = 4'(i);
                b = (runs[r].pat == 0) ? 4'(15 - i) : 4'd0;
                c = (runs[r].pat == 0) ? 1'(i % 2) : 1'b0;
                sum = 5'(a) + 5'(b) + 5'(c);
                m = 5'd0;
                if (runs[r].fidx == -1 || runs[r].fidx == i) begin
                    if (runs[r].fmode == 1) m = sum & 5'b00100;
                    else if (runs[r].fmode == 2) m = sum;
                    else m = 5'd0;
                end
                step(1'b0, 1'b0, 1'b0, 1'b0, a, b, c, m);
            end
            for (int j = 0; j < cur_lat; j++) begin
                step(1'b0, (runs[r].inst == 0) && (j == cur_lat - 1),
                     1'b0, (runs[r].inst == 1) && (j == cur_lat - 1),
                     4'd0, 4'd0, 1'b0, 5'd0);
            end
            settle();
            chk_end($sformatf("run%0d", r), runs[r].inst, runs[r].exp_vec, runs[r].exp_err,
                    runs[r].exp_pass, runs[r].exp_cvld, runs[r].exp_ca, runs[r].exp_cb,
                    runs[r].exp_ccin, runs[r].exp_cs, runs[r].exp_ccout);
        end

        // early stop while still filling (LAT=3)
        cur_lat = 3;
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 5'd0);
        settle();
        snap(1);
        chk("early done", o_done, 1);
        chk("early vec_cnt", o_vec, 0);
        chk("early pass", o_pass, 0);
        chk("early busy", o_busy, 0);

        // randomized runs on u0 against the adder model
        cur_lat = 1;
        for (int r = 0; r < 4; r++) begin
            int         n, nf;
            bit         got;
            logic [3:0] a, b, fa, fb, fs;
            logic       c, fc, fco, f;
            logic [4:0] m, sh;
            n = int'($urandom_range(30, 4));
            nf = 0; got = 1'b0;
            fa = 4'd0; fb = 4'd0; fs = 4'd0; fc = 1'b0; fco = 1'b0;
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
            for (int i = 0; i < n; i++) begin
                a = 4'($urandom_range(15, 0));
                b = 4'($urandom_range(15, 0));
                c = 1'($urandom_range(1, 0));
                f = ($urandom_range(3, 0) == 0);
                m = f ? 5'($urandom_range(31, 1)) : 5'd0;
                if (f) begin
                    nf++;
                    if (!got) begin
                        got = 1'b1;
                        sh = (5'(a) + 5'(b) + 5'(c)) ^ m;
                        fa = a; fb = b; fc = c; fs = sh[3:0]; fco = sh[4];
                    end
                end
                step(1'b0, 1'b0, 1'b0, 1'b0, a, b, c, m);
            end
            step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
            settle();
            chk_end($sformatf("rand%0d", r), 0, n, nf, (nf == 0) ? 1 : 0, int'(got),
                    int'(fa), int'(fb), int'(fc), int'(fs), int'(fco));
        end

        // asynchronous reset in the middle of CHECK
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 4'(i), 4'(9 - i), 1'b1, (i == 2) ? 5'd1 : 5'd0);
        end
        settle();
        snap(0);
        chk("mid busy before rst", o_busy, 1);
        chk("mid vec_cnt before rst", o_vec, 5);
        #2;
        rst = 1'b1;
        #1;
        snap(0);
        chk("async rst busy", o_busy, 0);
        chk("async rst done", o_done, 0);
        chk("async rst pass", o_pass, 0);
        chk("async rst vec_cnt", o_vec, 0);
        chk("async rst err_cnt", o_err, 0);
        chk("async rst cap_vld", o_cvld, 0);
        @(negedge clk);
        rst = 1'b0;

        // start and stop together in IDLE: start wins
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 5'd0);
        settle();
        snap(0);
        chk("start+stop busy", o_busy, 1);
        chk("start+stop done", o_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
